// File: rtl/bram_bist_pkg.sv
// Shared types and pattern helper for the BRAM self-test sequencer.
package bram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } bist_state_t;

    localparam logic [31:0] PAT_OR    = 32'h55000;
    localparam int          PAT_SHIFT = 20;

    function automatic logic [31:0] pat(
        input logic [31:0] a,
        input int          width
    );
        logic [31:0] v;
        logic [31:0] m;
        v = a | (a << PAT_SHIFT) | PAT_OR;
        m = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return v & m;
    endfunction

endpackage

// File: rtl/bram_bist_cmp_pipe.sv
// Expected-data delay line aligned to BRAM read latency, plus the
// 4-state-safe read-data comparator.
module bram_bist_cmp_pipe
    import bram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_exp,
    input  logic [DATA_WIDTH-1:0] rq,
    output logic                  cmp_valid,
    output logic                  cmp_err,
    output logic [ADDR_WIDTH-1:0] cmp_addr
);

    logic [READ_LATENCY-1:0] v_q;
    logic [ADDR_WIDTH-1:0]   a_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   e_q [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                a_q[i] <= '0;
                e_q[i] <= '0;
            end
        end else begin
            v_q[0] <= in_valid;
            a_q[0] <= in_addr;
            e_q[0] <= in_exp;
            for (int i = 1; i < READ_LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
                e_q[i] <= e_q[i-1];
            end
        end
    end

    assign cmp_valid = v_q[READ_LATENCY-1];
    assign cmp_addr  = a_q[READ_LATENCY-1];
    // X or Z on rq must register as a mismatch
    assign cmp_err   = cmp_valid && (rq !== e_q[READ_LATENCY-1]);

endmodule

// File: rtl/bram_bist_ctrl.sv
// BRAM write/read-back self-test sequencer for one port.
// Define BRAM_BIST_INV_PASS_EN to add a second pass with inverted pattern.
module bram_bist_ctrl
    import bram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    addr_lo,
    input  logic [ADDR_WIDTH-1:0]    addr_hi,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     wce,
    output logic [ADDR_WIDTH-1:0]    wa,
    output logic [DATA_WIDTH-1:0]    wd,
    output logic                     rce,
    output logic [ADDR_WIDTH-1:0]    ra,
    input  logic [DATA_WIDTH-1:0]    rq
);

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    bist_state_t           state;
    logic [ADDR_WIDTH-1:0] lo_q;
    logic [ADDR_WIDTH-1:0] hi_q;
    logic [ADDR_WIDTH-1:0] cur;
    logic                  empty_q;
    logic [1:0]            drain_cnt;

    logic                     cmp_valid;
    logic                     cmp_err;
    logic [ADDR_WIDTH-1:0]    cmp_addr;
    logic [DATA_WIDTH-1:0]    inv_mask;
    logic [DATA_WIDTH-1:0]    wd_d;
    logic [DATA_WIDTH-1:0]    exp_d;
    logic [ERR_CNT_WIDTH-1:0] err_nxt;

`ifdef BRAM_BIST_INV_PASS_EN
    logic pass_idx;
    assign inv_mask = {DATA_WIDTH{pass_idx}};
`else
    assign inv_mask = '0;
`endif

    assign wd_d  = DATA_WIDTH'(pat(32'(cur), DATA_WIDTH)) ^ inv_mask;
    assign exp_d = DATA_WIDTH'(pat(32'(ra), DATA_WIDTH)) ^ inv_mask;

    always_comb begin
        err_nxt = err_cnt;
        if (cmp_err && err_cnt != ERR_MAX)
            err_nxt = err_cnt + ERR_CNT_WIDTH'(1);
    end

    bram_bist_cmp_pipe #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rce),
        .in_addr   (ra),
        .in_exp    (exp_d),
        .rq        (rq),
        .cmp_valid (cmp_valid),
        .cmp_err   (cmp_err),
        .cmp_addr  (cmp_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            wce            <= 1'b0;
            rce            <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            wa             <= '0;
            ra             <= '0;
            wd             <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            cur            <= '0;
            empty_q        <= 1'b0;
            drain_cnt      <= '0;
`ifdef BRAM_BIST_INV_PASS_EN
            pass_idx       <= 1'b0;
`endif
        end else begin
            wce <= 1'b0;
            rce <= 1'b0;
            if (cmp_err) begin
                err_cnt <= err_nxt;
                if (err_cnt == '0)
                    first_err_addr <= cmp_addr;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lo_q           <= addr_lo;
                        hi_q           <= addr_hi;
                        cur            <= addr_lo;
                        empty_q        <= (addr_hi < addr_lo);
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
`ifdef BRAM_BIST_INV_PASS_EN
                        pass_idx       <= 1'b0;
`endif
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    if (empty_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        wce <= 1'b1;
                        wa  <= cur;
                        wd  <= wd_d;
                        // hi check before increment keeps cur from wrapping
                        if (cur == hi_q) begin
                            cur   <= lo_q;
                            state <= READ;
                        end else begin
                            cur <= cur + ADDR_WIDTH'(1);
                        end
                    end
                end
                READ: begin
                    rce <= 1'b1;
                    ra  <= cur;
                    if (cur == hi_q) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        cur <= cur + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(READ_LATENCY)) begin
`ifdef BRAM_BIST_INV_PASS_EN
                        if (!pass_idx) begin
                            pass_idx <= 1'b1;
                            cur      <= lo_q;
                            state    <= WRITE;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                        end
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
`endif
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_bist_ctrl.sv
// Directed checks of bram_bist_ctrl against behavioural BRAM models.
module tb_bram_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Instance A: 32-bit data, latency 1, 8-bit error counter
    logic        start_a = 1'b0;
    logic [9:0]  lo_a = '0, hi_a = '0;
    logic        busy_a, done_a, pass_a, wce_a, rce_a;
    logic [7:0]  err_a;
    logic [9:0]  fea_a, wa_a, ra_a;
    logic [31:0] wd_a, rq_a;
    int          mode_a = 0;
    logic [31:0] mem_a [1024];

    bram_bist_ctrl #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32),
        .READ_LATENCY(1), .ERR_CNT_WIDTH(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .addr_lo(lo_a), .addr_hi(hi_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_err_addr(fea_a),
        .wce(wce_a), .wa(wa_a), .wd(wd_a),
        .rce(rce_a), .ra(ra_a), .rq(rq_a)
    );

    always @(posedge clk) begin
        if (wce_a) mem_a[wa_a] <= wd_a;
        if (rce_a) begin
            if (mode_a == 1) rq_a <= 32'h0;
            else if (mode_a == 2 && ra_a == 10'h010)
                rq_a <= mem_a[ra_a] | 32'h8;
            else rq_a <= mem_a[ra_a];
        end
    end

    int wr_a = 0, rd_a = 0, ovl_a = 0;
    always @(negedge clk) begin
        if (wce_a) wr_a++;
        if (rce_a) rd_a++;
        if (wce_a && rce_a) ovl_a++;
    end

    // Instance B: 8-bit data, latency 2
    logic        start_b = 1'b0;
    logic [9:0]  lo_b = '0, hi_b = '0;
    logic        busy_b, done_b, pass_b, wce_b, rce_b;
    logic [15:0] err_b;
    logic [9:0]  fea_b, wa_b, ra_b;
    logic [7:0]  wd_b, rq_b, r1_b;
    logic [7:0]  mem_b [1024];

    bram_bist_ctrl #(
        .ADDR_WIDTH(10), .DATA_WIDTH(8),
        .READ_LATENCY(2), .ERR_CNT_WIDTH(16)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .addr_lo(lo_b), .addr_hi(hi_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_err_addr(fea_b),
        .wce(wce_b), .wa(wa_b), .wd(wd_b),
        .rce(rce_b), .ra(ra_b), .rq(rq_b)
    );

    always @(posedge clk) begin
        if (wce_b) mem_b[wa_b] <= wd_b;
        r1_b <= mem_b[ra_b];
        rq_b <= r1_b;
    end

    logic [7:0] wdq_b [$];
    int oow_b = 0, rd_b = 0, ovl_b = 0;
    always @(negedge clk) begin
        if (wce_b) wdq_b.push_back(wd_b);
        if (rce_b) rd_b++;
        if ((wce_b && wa_b < 10'd1020) || (rce_b && ra_b < 10'd1020))
            oow_b++;
        if (wce_b && rce_b) ovl_b++;
    end

    task automatic run_a(input logic [9:0] lo, input logic [9:0] hi,
                         input int spur, output int cyc);
        @(negedge clk);
        lo_a = lo; hi_a = hi; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 1;
        while (!done_a && cyc < 5000) begin
            if (cyc == spur) begin
                start_a = 1'b1; lo_a = 10'd100; hi_a = 10'd50;
            end else begin
                start_a = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        chk("done_reached_a", done_a, 1'b1);
    endtask

    int cyc, w0, r0, o0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_pass", pass_a, 1'b0);
        chk("rst_wce_rce", {wce_a, rce_a}, 2'b00);
        chk("rst_err", err_a, 8'd0);
        chk("rst_fea", fea_a, 10'd0);
        chk("rst_wa_ra_wd", {wa_a, ra_a, wd_a}, 52'd0);
        @(negedge clk);
        rst = 1'b0;

        // full half-window, clean memory
        w0 = wr_a; r0 = rd_a; o0 = ovl_a;
        run_a(10'd0, 10'd511, 0, cyc);
        chk("t1_cycles", cyc, 1027);
        chk("t1_writes", wr_a - w0, 512);
        chk("t1_reads", rd_a - r0, 512);
        chk("t1_pass", pass_a, 1'b1);
        chk("t1_err", err_a, 8'd0);
        chk("t1_busy", busy_a, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_done_hold", done_a, 1'b1);

        // bit 3 stuck-at-1 at 0x010
        mode_a = 2;
        run_a(10'd0, 10'd511, 0, cyc);
        chk("t2_pass", pass_a, 1'b0);
        chk("t2_err", err_a, 8'd1);
        chk("t2_fea", fea_a, 10'h010);

        // all reads zero over the full range: counter saturates
        mode_a = 1;
        run_a(10'd0, 10'd1023, 0, cyc);
        chk("t3_cycles", cyc, 2051);
        chk("t3_err_sat", err_a, 8'd255);
        chk("t3_fea", fea_a, 10'd0);
        chk("t3_pass", pass_a, 1'b0);
        mode_a = 0;

        // empty window
        w0 = wr_a; r0 = rd_a;
        @(negedge clk);
        lo_a = 10'd5; hi_a = 10'd4; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("t4_busy", {busy_a, done_a}, 2'b10);
        @(posedge clk); #1;
        chk("t4_done", {busy_a, done_a}, 2'b01);
        chk("t4_pass", pass_a, 1'b1);
        chk("t4_err", err_a, 8'd0);
        chk("t4_no_access", (wr_a - w0) + (rd_a - r0), 0);

        // reset during read phase
        mode_a = 1;
        @(negedge clk);
        lo_a = 10'd0; hi_a = 10'd511; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (!(rce_a && ra_a == 10'd200) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t5_reach_200", rce_a && ra_a == 10'd200, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_abort", {busy_a, rce_a, done_a}, 3'b000);
        chk("t5_err", err_a, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        mode_a = 0;
        run_a(10'd0, 10'd15, 0, cyc);
        chk("t5_cycles", cyc, 35);
        chk("t5_pass", pass_a, 1'b1);
        chk("t5_err_after", err_a, 8'd0);

        // start while busy is ignored
        w0 = wr_a;
        run_a(10'd0, 10'd15, 5, cyc);
        chk("t6_cycles", cyc, 35);
        chk("t6_writes", wr_a - w0, 16);
        chk("t6_pass", pass_a, 1'b1);
        chk("t6_no_overlap", ovl_a - o0, 0);

        // narrow data, latency 2, window at top of address space
        @(negedge clk);
        lo_b = 10'd1020; hi_b = 10'd1023; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 1;
        while (!done_b && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b_done", done_b, 1'b1);
        chk("b_cycles", cyc, 12);
        chk("b_nwrites", wdq_b.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b_wd%0d", i),
                (i < wdq_b.size()) ? wdq_b[i] : 8'hxx, 8'hfc + 8'(i));
        chk("b_reads", rd_b, 4);
        chk("b_no_wrap", oow_b, 0);
        chk("b_no_overlap", ovl_b, 0);
        chk("b_pass", pass_b, 1'b1);
        chk("b_err", err_b, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
